// File: rtl/conv1d_pkg.sv
// conv1d_pkg: default parameters and arithmetic helpers shared by conv1d_mac.
// Build option: CONV1D_MAC_SAT_EN adds the saturating accumulator adder.
package conv1d_pkg;

    localparam int unsigned DEFAULT_WIDTH     = 8;
    localparam int unsigned DEFAULT_LANES     = 4;
    localparam int unsigned DEFAULT_TAPS      = 3;
    localparam int unsigned DEFAULT_ACC_WIDTH = 32;

    // Helpers work on 64-bit carriers; callers truncate to their own width.
    typedef struct packed {
        logic signed [63:0] value;
        logic               sat;
    } sat_sum_t;

    // Sign-extend the low prod_width bits of prod to 64 bits.
    function automatic logic signed [63:0] sext_product(input logic [63:0] prod,
                                                        input int unsigned prod_width);
        logic signed [63:0] r;
        r = prod << (64 - prod_width);
        r = r >>> (64 - prod_width);
        return r;
    endfunction

`ifdef CONV1D_MAC_SAT_EN
    // Add two acc_width-bit signed values (already sign-extended) and clamp
    // the result into the acc_width signed range.
    function automatic sat_sum_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int unsigned acc_width);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_sum_t           r;
        sum     = a + b;
        hi      = (64'sd1 <<< (acc_width - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        r.value = sum;
        r.sat   = 1'b0;
        if (sum > hi) begin
            r.value = hi;
            r.sat   = 1'b1;
        end else if (sum < lo) begin
            r.value = lo;
            r.sat   = 1'b1;
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/conv1d_mac_if.sv
// conv1d_mac_if: input beat and result streams of conv1d_mac.
// slave is the MAC side, master is the streamer/writeback side.
interface conv1d_mac_if
    import conv1d_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned LANES     = DEFAULT_LANES,
    parameter int unsigned ACC_WIDTH = DEFAULT_ACC_WIDTH
) ();

    logic                        in_valid_i;
    logic                        in_ready_o;
    logic [LANES*WIDTH-1:0]      data_i;
    logic [LANES*WIDTH-1:0]      weight_i;
    logic                        out_valid_o;
    logic                        out_ready_i;
    logic signed [ACC_WIDTH-1:0] acc_o;
    logic                        overflow_o;

    modport slave (
        input  in_valid_i, data_i, weight_i, out_ready_i,
        output in_ready_o, out_valid_o, acc_o, overflow_o
    );

    modport master (
        output in_valid_i, data_i, weight_i, out_ready_i,
        input  in_ready_o, out_valid_o, acc_o, overflow_o
    );

endinterface

// File: rtl/conv1d_mul_stage.sv
// conv1d_mul_stage: LANES signed multipliers and the stage-1 pipeline register.
module conv1d_mul_stage
    import conv1d_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned LANES = DEFAULT_LANES
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         advance_i,
    input  logic                         beat_i,
    input  logic                         last_i,
    input  logic [LANES*WIDTH-1:0]       data_i,
    input  logic [LANES*WIDTH-1:0]       weight_i,
    output logic [LANES*2*WIDTH-1:0]     prod_o,
    output logic                         s1_valid_o,
    output logic                         s1_last_o
);

    localparam int unsigned PROD_WIDTH = 2 * WIDTH;

    logic [LANES*PROD_WIDTH-1:0] prod_c;

    // Per-lane signed products of the beat currently on the input.
    always_comb begin
        logic signed [PROD_WIDTH-1:0] a;
        logic signed [PROD_WIDTH-1:0] b;
        a      = '0;
        b      = '0;
        prod_c = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            a = $signed(data_i[k*WIDTH +: WIDTH]);
            b = $signed(weight_i[k*WIDTH +: WIDTH]);
            prod_c[k*PROD_WIDTH +: PROD_WIDTH] = a * b;
        end
    end

    // Stage-1 register: captures accepted beats, holds while stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_o     <= '0;
            s1_valid_o <= 1'b0;
            s1_last_o  <= 1'b0;
        end else if (clear_i) begin
            s1_valid_o <= 1'b0;
            s1_last_o  <= 1'b0;
        end else if (advance_i) begin
            s1_valid_o <= beat_i;
            s1_last_o  <= beat_i & last_i;
            if (beat_i) begin
                prod_o <= prod_c;
            end
        end
    end

endmodule

// File: rtl/conv1d_mac.sv
// conv1d_mac: streaming multiply-accumulate, one kernel dot-product per TAPS beats.
// Build option: CONV1D_MAC_SAT_EN saturates accumulation and drives overflow_o;
// without it accumulation wraps and overflow_o is 0.
module conv1d_mac
    import conv1d_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned LANES     = DEFAULT_LANES,
    parameter int unsigned TAPS      = DEFAULT_TAPS,
    parameter int unsigned ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    conv1d_mac_if.slave  bus
);

    localparam int unsigned PROD_WIDTH = 2 * WIDTH;
    localparam int unsigned CNT_WIDTH  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_TAP = CNT_WIDTH'(TAPS - 1);

    logic                        advance;
    logic                        beat;
    logic                        tap_last;
    logic [CNT_WIDTH-1:0]        tap_cnt;
    logic [LANES*PROD_WIDTH-1:0] prod;
    logic                        s1_valid;
    logic                        s1_last;
    logic signed [ACC_WIDTH-1:0] lane_sum;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] result;
    logic                        out_valid;

    assign advance         = ~out_valid | bus.out_ready_i;
    assign beat            = bus.in_valid_i & advance & ~clear_i;
    assign tap_last        = (tap_cnt == LAST_TAP);
    assign bus.in_ready_o  = advance;
    assign bus.out_valid_o = out_valid;
    assign bus.acc_o       = result;

    // Tap position of the next accepted beat; wraps after the last tap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tap_cnt <= '0;
        end else if (clear_i) begin
            tap_cnt <= '0;
        end else if (beat) begin
            tap_cnt <= tap_last ? '0 : tap_cnt + 1'b1;
        end
    end

    conv1d_mul_stage #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_mul (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear_i),
        .advance_i  (advance),
        .beat_i     (beat),
        .last_i     (tap_last),
        .data_i     (bus.data_i),
        .weight_i   (bus.weight_i),
        .prod_o     (prod),
        .s1_valid_o (s1_valid),
        .s1_last_o  (s1_last)
    );

    // Sum of all lane products, each sign-extended to the accumulator width.
    always_comb begin
        logic signed [63:0] ext;
        ext      = '0;
        lane_sum = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            ext      = sext_product(64'(prod[k*PROD_WIDTH +: PROD_WIDTH]), PROD_WIDTH);
            lane_sum = lane_sum + ACC_WIDTH'(ext);
        end
    end

`ifdef CONV1D_MAC_SAT_EN
    sat_sum_t acc_sum;
    logic     sat_hit;
    logic     grp_ovf;
    logic     ovf_q;

    // Saturating accumulator update; sat_hit flags a clamped addition.
    always_comb begin
        logic signed [63:0] a;
        logic signed [63:0] b;
        a        = acc;
        b        = lane_sum;
        acc_sum  = sat_add(a, b, ACC_WIDTH);
        acc_next = ACC_WIDTH'(acc_sum.value);
        sat_hit  = acc_sum.sat;
    end

    // Sticky per-group saturation flag, handed to overflow_o with the result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grp_ovf <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clear_i) begin
            grp_ovf <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (advance && s1_valid) begin
            if (s1_last) begin
                ovf_q   <= grp_ovf | sat_hit;
                grp_ovf <= 1'b0;
            end else begin
                grp_ovf <= grp_ovf | sat_hit;
            end
        end
    end

    assign bus.overflow_o = ovf_q;
`else
    // Wrapping accumulator update.
    always_comb begin
        acc_next = acc + lane_sum;
    end

    assign bus.overflow_o = 1'b0;
`endif

    // Accumulate each beat; the last beat of a group loads the output
    // register. The accumulator restarts at zero so the first beat of the
    // next group loads the lane sum alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else if (clear_i) begin
            acc       <= '0;
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid & s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    result <= acc_next;
                    acc    <= '0;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv1d_mac.sv
// tb_conv1d_mac: directed and randomized checks of conv1d_mac (TAPS=3 and TAPS=1)
// against a queue-based reference model. Honours CONV1D_MAC_SAT_EN.
module tb_conv1d_mac;

    localparam int unsigned W  = 8;
    localparam int unsigned L  = 4;
    localparam int unsigned T  = 3;
`ifdef CONV1D_MAC_SAT_EN
    localparam int unsigned AW        = 17;
    localparam bit          SAT_BUILD = 1'b1;
`else
    localparam int unsigned AW        = 32;
    localparam bit          SAT_BUILD = 1'b0;
`endif
    localparam int unsigned DW = L * W;

    typedef logic [DW-1:0] beat_t;
    typedef struct { longint val; bit ovf; } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic clear3;
    logic clear1;

    int checks   = 0;
    int failures = 0;

    exp_t   q[$];
    longint m_grp;
    bit     m_ovf;
    int     m_cnt;
    int     hs_count;
    longint hs_val;
    bit     hs_ovf;
    bit     prev_hold;
    longint hist[20];

    always #5 clk = ~clk;

    conv1d_mac_if #(.WIDTH(W), .LANES(L), .ACC_WIDTH(AW)) bus3 ();
    conv1d_mac_if #(.WIDTH(W), .LANES(L), .ACC_WIDTH(32)) bus1 ();

    conv1d_mac #(.WIDTH(W), .LANES(L), .TAPS(T), .ACC_WIDTH(AW)) u_dut3 (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear3),
        .bus     (bus3.slave)
    );

    conv1d_mac #(.WIDTH(W), .LANES(L), .TAPS(1), .ACC_WIDTH(32)) u_dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (clear1),
        .bus     (bus1.slave)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sign-extend the low aw bits of x: two's complement wrap to aw bits.
    function automatic longint wrap_to(input longint x, input int unsigned aw);
        longint r;
        r = x << (64 - aw);
        return r >>> (64 - aw);
    endfunction

    function automatic longint lanesum(input beat_t d, input beat_t w, input int unsigned aw);
        longint s;
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        s = 0;
        for (int k = 0; k < L; k++) begin
            a = d[k*W +: W];
            b = w[k*W +: W];
            s += longint'(a) * longint'(b);
        end
        return wrap_to(s, aw);
    endfunction

    function automatic void model_flush();
        q.delete();
        m_grp = 0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endfunction

    function automatic void model_beat(input beat_t d, input beat_t w);
        longint t;
        longint hi;
        longint lo;
        exp_t   e;
        hi = (longint'(1) <<< (AW - 1)) - 1;
        lo = -hi - 1;
        t  = m_grp + lanesum(d, w, AW);
        if (SAT_BUILD) begin
            if (t > hi) begin
                t     = hi;
                m_ovf = 1'b1;
            end else if (t < lo) begin
                t     = lo;
                m_ovf = 1'b1;
            end
        end else begin
            t = wrap_to(t, AW);
        end
        m_grp = t;
        m_cnt++;
        if (m_cnt == T) begin
            e.val = m_grp;
            e.ovf = m_ovf;
            q.push_back(e);
            m_grp = 0;
            m_ovf = 1'b0;
            m_cnt = 0;
        end
    endfunction

    // One clock of the TAPS=3 DUT: drive at negedge, observe 1 ns later.
    task automatic cycle(input bit v, input beat_t d, input beat_t w, input bit rdy, input bit clr);
        longint acc;
        @(negedge clk);
        bus3.in_valid_i  = v;
        bus3.data_i      = d;
        bus3.weight_i    = w;
        bus3.out_ready_i = rdy;
        clear3           = clr;
        #1;
        acc = longint'(bus3.acc_o);
        if (prev_hold) check("hold_valid", longint'(bus3.out_valid_o), 1);
        if (clr) begin
            model_flush();
            prev_hold = 1'b0;
        end else begin
            if (bus3.out_valid_o) begin
                check("out_pending", longint'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    check("acc", acc, q[0].val);
                    check("ovf", longint'(bus3.overflow_o), longint'(q[0].ovf));
                    if (rdy) begin
                        hs_count++;
                        hs_val = acc;
                        hs_ovf = bus3.overflow_o;
                        void'(q.pop_front());
                    end
                end
            end
            if (v && bus3.in_ready_o) model_beat(d, w);
            prev_hold = bus3.out_valid_o && !rdy;
        end
    endtask

    task automatic drain(input string tag, input bit use_exp, input longint exp);
        int start;
        start = hs_count;
        for (int i = 0; i < 10 && hs_count == start; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check({tag, "_seen"}, longint'(hs_count - start), 1);
        if (use_exp && hs_count != start) check(tag, hs_val, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst              = 1'b1;
        clear3           = 1'b0;
        clear1           = 1'b0;
        bus3.in_valid_i  = 1'b0;
        bus3.data_i      = '0;
        bus3.weight_i    = '0;
        bus3.out_ready_i = 1'b1;
        bus1.in_valid_i  = 1'b0;
        bus1.data_i      = '0;
        bus1.weight_i    = '0;
        bus1.out_ready_i = 1'b1;
        hs_count         = 0;
        hs_val           = 0;
        hs_ovf           = 1'b0;
        prev_hold        = 1'b0;
        model_flush();

        // Reset values.
        #2;
        check("rst_in_ready", longint'(bus3.in_ready_o), 1);
        check("rst_out_valid", longint'(bus3.out_valid_o), 0);
        check("rst_acc", longint'(bus3.acc_o), 0);
        check("rst_ovf", longint'(bus3.overflow_o), 0);
        check("rst1_in_ready", longint'(bus1.in_ready_o), 1);
        check("rst1_out_valid", longint'(bus1.out_valid_o), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Group 1: data 1, weights 1,2,3 -> 24 two cycles after the last beat.
        cycle(1'b1, 32'h01010101, 32'h01010101, 1'b1, 1'b0);
        cycle(1'b1, 32'h01010101, 32'h02020202, 1'b1, 1'b0);
        cycle(1'b1, 32'h01010101, 32'h03030303, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("lat_early", longint'(bus3.out_valid_o), 0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("lat_due", longint'(bus3.out_valid_o), 1);
        check("grp1", hs_val, 24);

        // Group 2: -128 x -128 on every lane.
        repeat (3) cycle(1'b1, 32'h80808080, 32'h80808080, 1'b1, 1'b0);
        drain("grp2", !SAT_BUILD, 196608);

        // Backpressure: result held for 5 cycles while new beats are offered.
        repeat (3) cycle(1'b1, DW'($urandom()), DW'($urandom()), 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, DW'($urandom()), DW'($urandom()), 1'b0, 1'b0);
            check("bp_in_ready", longint'(bus3.in_ready_o), 0);
            check("bp_valid", longint'(bus3.out_valid_o), 1);
        end
        repeat (3) cycle(1'b1, DW'($urandom()), DW'($urandom()), 1'b1, 1'b0);
        drain("bp_next", 1'b0, 0);
        check("bp_queue_empty", longint'(q.size()), 0);

        // Clear after beat 2 with a valid beat present; that beat is dropped.
        repeat (2) cycle(1'b1, DW'($urandom()), DW'($urandom()), 1'b1, 1'b0);
        cycle(1'b1, DW'($urandom()), DW'($urandom()), 1'b1, 1'b1);
        repeat (3) cycle(1'b1, 32'h01010101, 32'h01010101, 1'b1, 1'b0);
        drain("clr_grp", 1'b1, 12);

        // Randomized traffic with random backpressure and occasional clear.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, DW'($urandom()), DW'($urandom()),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end
        for (int i = 0; i < 40 && q.size() > 0; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("rand_drain", longint'(q.size()), 0);
        cycle(1'b0, '0, '0, 1'b1, 1'b1);

`ifdef CONV1D_MAC_SAT_EN
        // Saturation: 3 x (4 x 127*127) clamps at 2^16-1; flag clears next group.
        repeat (3) cycle(1'b1, 32'h7f7f7f7f, 32'h7f7f7f7f, 1'b1, 1'b0);
        drain("sat_val", 1'b1, 65535);
        check("sat_ovf", longint'(hs_ovf), 1);
        repeat (3) cycle(1'b1, 32'h01010101, 32'h01010101, 1'b1, 1'b0);
        drain("sat_small", 1'b1, 12);
        check("sat_ovf_clr", longint'(hs_ovf), 0);
`endif

        // Asynchronous reset with a held result and a partial group.
        repeat (4) cycle(1'b1, DW'($urandom()), DW'($urandom()), 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        check("pre_rst_valid", longint'(bus3.out_valid_o), 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", longint'(bus3.out_valid_o), 0);
        check("arst_in_ready", longint'(bus3.in_ready_o), 1);
        check("arst_acc", longint'(bus3.acc_o), 0);
        check("arst_ovf", longint'(bus3.overflow_o), 0);
        model_flush();
        prev_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 32'h01010101, 32'h01010101, 1'b1, 1'b0);
        cycle(1'b1, 32'h01010101, 32'h02020202, 1'b1, 1'b0);
        cycle(1'b1, 32'h01010101, 32'h03030303, 1'b1, 1'b0);
        drain("post_rst", 1'b1, 24);

        // TAPS=1: continuous traffic, one result per cycle equal to its lane sum.
        for (int i = 0; i < 20; i++) begin
            beat_t d;
            beat_t w;
            d = DW'($urandom());
            w = DW'($urandom());
            @(negedge clk);
            bus1.in_valid_i  = 1'b1;
            bus1.data_i      = d;
            bus1.weight_i    = w;
            bus1.out_ready_i = 1'b1;
            hist[i]          = lanesum(d, w, 32);
            #1;
            if (i >= 2) begin
                check("t1_valid", longint'(bus1.out_valid_o), 1);
                check("t1_acc", longint'(bus1.acc_o), hist[i-2]);
            end
        end
        @(negedge clk);
        bus1.in_valid_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
